ctrl_pipeline: RTL and testbench
================================

// Module: ctrl_pipeline
// PURPOSE
//  Carries control_unit decode outputs down the pipeline as ID/EX, EX/MEM and MEM/WB control registers.
//  Detects load-use and branch hazards, generates stall/flush for the fetch/decode front end, and
//  produces EX operand forwarding selects. Sits between decode and the EX/MEM/WB datapath.
// PARAMETERS
//  REG_W   4  register index width (16 GPRs; R0 hardwired zero, never a hazard source/target)
//  FWD_EN  1  1: forward from MEM/WB; 0: forwarding off, fwd_* tied 00, every RAW on EX/MEM stalls
// PORTS
//  clk            in   1      rising-edge clock
//  rst_n          in   1      asynchronous, active-low reset
//  id_valid       in   1      decode holds a real instruction
//  id_reg_wren    in   1      control_unit reg_wren
//  id_mem_to_reg  in   1      control_unit mem_to_reg (load)
//  id_mem_wr      in   1      control_unit mem_wr (store)
//  id_alu_src     in   1      control_unit alu_src
//  id_dst_reg_sel in   1      control_unit dst_reg_sel (1 = rd, 0 = rt)
//  id_branch      in   1      control_unit branch
//  id_rs,id_rt,id_rd in REG_W decoded register fields
//  id_rs_used,id_rt_used in 1 instruction actually reads rs / rt
//  ex_br_taken    in   1      EX resolved a taken branch (meaningful only when ex stage valid & branch)
//  mem_busy       in   1      data memory not ready; freezes whole pipe
//  ex_valid,ex_reg_wren,ex_mem_to_reg,ex_mem_wr,ex_alu_src,ex_branch out 1 ID/EX controls
//  ex_rs,ex_rt    out  REG_W  EX source registers
//  mem_valid,mem_reg_wren,mem_mem_to_reg,mem_mem_wr out 1 EX/MEM controls
//  wb_reg_wren    out  1      gated write enable: wb_valid & reg_wren
//  wb_mem_to_reg  out  1      WB mux select
//  wb_dst         out  REG_W  WB destination register
//  fwd_a,fwd_b    out  2      EX operand A(rs)/B(rt) select: 00 regfile, 01 EX/MEM result, 10 MEM/WB result
//  stall_fe       out  1      hold PC and IF/ID
//  flush_fe       out  1      clear IF/ID (wrong-path)
// BEHAVIOUR
//  Reset: every stage register valid=0, all controls/regs 0; hence all outputs 0, fwd 00. Async assert, sync release.
//  Latency: accepted ID controls appear on ex_* next edge, mem_* +2, wb_* +3. dst = dst_reg_sel ? rd : rt,
//   computed at ID/EX capture and carried. Invalid stage => all its controls forced 0 (bubble).
//  Priority per cycle: mem_busy > branch flush > load-use/RAW stall > normal advance.
//  mem_busy=1: all three stage regs hold; stall_fe=1; flush_fe=0 (taken branch stays in EX, flushes when busy drops).
//  Flush: ex_valid & ex_branch & ex_br_taken -> flush_fe=1, stall_fe=0; ID/EX loads bubble; EX/MEM takes branch.
//  Load-use: ex_valid & ex_mem_to_reg & ex_dst!=0 & id_valid & ((id_rs_used & id_rs==ex_dst) |
//   (id_rt_used & id_rt==ex_dst)) -> stall_fe=1 one cycle, ID/EX loads bubble, EX/MEM/WB advance.
//  FWD_EN=0: stall same way for any reg_wren producer in EX or MEM stage matching a used source.
//  Forwarding (combinational from stage regs): MEM match (mem_valid & reg_wren & dst!=0 & dst==src) wins
//   over WB match; else 00. Store data (rt) forwarded identically. Load results forward only from WB.
//  Branch instruction itself never writes; reg_wren carried as decoded.
// STRUCTURE
//  Shared header (beside opcodes.vh): FWD_REG=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10; control bundle field widths.
//  Sub-module ctrl_stage_reg: valid + control bundle + dst, async reset, hold/bubble inputs; instanced 3x.
//  Hazard/forward logic is local combinational code in ctrl_pipeline.
// TESTING
//  LW R1 then ADD R2,R1,R3 back-to-back -> stall_fe=1 exactly 1 cycle, ex_valid=0 that cycle, then fwd_a=10.
//  ADD R1 then SUB R4,R1,R1 -> no stall, fwd_a=fwd_b=01; with one NOP between -> fwd=10.
//  Taken B in EX -> flush_fe=1 one cycle, next ex_valid=0; wrong-path SW never reaches mem_mem_wr.
//  mem_busy high 3 cycles with taken branch in EX -> outputs frozen, flush_fe=0, then 1 on release cycle.
//  Writes to R0 (ADD R0 then ADD R2,R0,R0) -> fwd 00, no stall; FWD_EN=0 run of case 2 -> 2-cycle stall.
//  rst_n low mid-stream (asynchronous, between edges) -> all outputs 0 immediately; first instr after release ex_* in 1 cycle.

Source files
------------

// File: rtl/ctrl_pipeline_pkg.sv
// rtl/ctrl_pipeline_pkg.sv - forwarding select encodings and control bundle layout
package ctrl_pipeline_pkg;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef struct packed {
    logic reg_wren;
    logic mem_to_reg;
    logic mem_wr;
    logic alu_src;
    logic branch;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  // The youngest producer wins: EX/MEM result over MEM/WB result over the regfile.
  function automatic logic [1:0] fwd_pick(input logic mem_hit, input logic wb_hit);
    if (mem_hit) return FWD_MEM;
    if (wb_hit)  return FWD_WB;
    return FWD_REG;
  endfunction

endpackage

// File: rtl/ctrl_stage_reg.sv
// rtl/ctrl_stage_reg.sv - one pipeline control register: valid bit plus payload
module ctrl_stage_reg
  import ctrl_pipeline_pkg::*;
#(
  parameter int PAY_W = CTRL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hold,
  input  logic             bubble,
  input  logic             in_valid,
  input  logic [PAY_W-1:0] in_pay,
  output logic             out_valid,
  output logic [PAY_W-1:0] out_pay
);

  // Hold keeps the stage, a bubble or an invalid source loads an all-zero slot, otherwise capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_pay   <= '0;
    end else if (!hold) begin
      if (bubble || !in_valid) begin
        out_valid <= 1'b0;
        out_pay   <= '0;
      end else begin
        out_valid <= 1'b1;
        out_pay   <= in_pay;
      end
    end
  end

endmodule

// File: rtl/ctrl_pipeline.sv
// rtl/ctrl_pipeline.sv - ID/EX, EX/MEM, MEM/WB control carry with hazard and forwarding logic
module ctrl_pipeline
  import ctrl_pipeline_pkg::*;
#(
  parameter int REG_W  = 4,
  parameter bit FWD_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic             id_reg_wren,
  input  logic             id_mem_to_reg,
  input  logic             id_mem_wr,
  input  logic             id_alu_src,
  input  logic             id_dst_reg_sel,
  input  logic             id_branch,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_rs_used,
  input  logic             id_rt_used,
  input  logic             ex_br_taken,
  input  logic             mem_busy,
  output logic             ex_valid,
  output logic             ex_reg_wren,
  output logic             ex_mem_to_reg,
  output logic             ex_mem_wr,
  output logic             ex_alu_src,
  output logic             ex_branch,
  output logic [REG_W-1:0] ex_rs,
  output logic [REG_W-1:0] ex_rt,
  output logic             mem_valid,
  output logic             mem_reg_wren,
  output logic             mem_mem_to_reg,
  output logic             mem_mem_wr,
  output logic             wb_reg_wren,
  output logic             wb_mem_to_reg,
  output logic [REG_W-1:0] wb_dst,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             stall_fe,
  output logic             flush_fe
);

  localparam int IDEX_W  = CTRL_W + 3 * REG_W;
  localparam int EXMEM_W = 3 + REG_W;
  localparam int MEMWB_W = 2 + REG_W;

  ctrl_t              id_ctrl;
  ctrl_t              ex_ctrl;
  logic [REG_W-1:0]   id_dst;
  logic [REG_W-1:0]   ex_dst;
  logic [REG_W-1:0]   mem_dst;
  logic [IDEX_W-1:0]  idex_q;
  logic [EXMEM_W-1:0] exmem_q;
  logic [MEMWB_W-1:0] memwb_q;
  logic               wb_valid;
  logic               wb_wren_raw;
  logic               idex_bubble;
  logic               ex_src_hit;
  logic               mem_src_hit;
  logic               load_use;
  logic               raw_unfwd;
  logic               hazard;
  logic               flush;

  assign id_ctrl = {id_reg_wren, id_mem_to_reg, id_mem_wr, id_alu_src, id_branch};
  assign id_dst  = id_dst_reg_sel ? id_rd : id_rt;

  ctrl_stage_reg #(.PAY_W(IDEX_W)) u_idex (
    .clk(clk), .rst_n(rst_n), .hold(mem_busy), .bubble(idex_bubble),
    .in_valid(id_valid), .in_pay({id_ctrl, id_dst, id_rs, id_rt}),
    .out_valid(ex_valid), .out_pay(idex_q)
  );

  assign {ex_ctrl, ex_dst, ex_rs, ex_rt} = idex_q;
  assign ex_reg_wren   = ex_ctrl.reg_wren;
  assign ex_mem_to_reg = ex_ctrl.mem_to_reg;
  assign ex_mem_wr     = ex_ctrl.mem_wr;
  assign ex_alu_src    = ex_ctrl.alu_src;
  assign ex_branch     = ex_ctrl.branch;

  ctrl_stage_reg #(.PAY_W(EXMEM_W)) u_exmem (
    .clk(clk), .rst_n(rst_n), .hold(mem_busy), .bubble(1'b0),
    .in_valid(ex_valid), .in_pay({ex_reg_wren, ex_mem_to_reg, ex_mem_wr, ex_dst}),
    .out_valid(mem_valid), .out_pay(exmem_q)
  );

  assign {mem_reg_wren, mem_mem_to_reg, mem_mem_wr, mem_dst} = exmem_q;

  ctrl_stage_reg #(.PAY_W(MEMWB_W)) u_memwb (
    .clk(clk), .rst_n(rst_n), .hold(mem_busy), .bubble(1'b0),
    .in_valid(mem_valid), .in_pay({mem_reg_wren, mem_mem_to_reg, mem_dst}),
    .out_valid(wb_valid), .out_pay(memwb_q)
  );

  assign {wb_wren_raw, wb_mem_to_reg, wb_dst} = memwb_q;
  assign wb_reg_wren = wb_valid & wb_wren_raw;

  // R0 never creates a dependency, so a zero destination never matches a source.
  assign ex_src_hit  = id_valid && (ex_dst != '0) &&
                       ((id_rs_used && (id_rs == ex_dst)) || (id_rt_used && (id_rt == ex_dst)));
  assign mem_src_hit = id_valid && (mem_dst != '0) &&
                       ((id_rs_used && (id_rs == mem_dst)) || (id_rt_used && (id_rt == mem_dst)));

  // A load's data exists only from WB onward, so its consumer waits one slot; without
  // forwarding every EX/MEM producer has to reach WB before the consumer may enter EX.
  assign load_use  = ex_valid & ex_mem_to_reg & ex_src_hit;
  assign raw_unfwd = (ex_valid & ex_reg_wren & ex_src_hit) | (mem_valid & mem_reg_wren & mem_src_hit);
  assign hazard    = load_use | (!FWD_EN & raw_unfwd);
  assign flush     = ex_valid & ex_branch & ex_br_taken;

  // Front-end control: a busy memory freezes everything, then a taken branch, then a data stall.
  always_comb begin
    stall_fe    = 1'b0;
    flush_fe    = 1'b0;
    idex_bubble = 1'b0;
    if (mem_busy) begin
      stall_fe = 1'b1;
    end else if (flush) begin
      flush_fe    = 1'b1;
      idex_bubble = 1'b1;
    end else if (hazard) begin
      stall_fe    = 1'b1;
      idex_bubble = 1'b1;
    end
  end

  // Operand selects; the load-use stall keeps a load in MEM from ever feeding a consumer in EX.
  always_comb begin
    fwd_a = FWD_REG;
    fwd_b = FWD_REG;
    if (FWD_EN) begin
      fwd_a = fwd_pick(mem_valid && mem_reg_wren && (mem_dst != '0) && (mem_dst == ex_rs),
                       wb_reg_wren && (wb_dst != '0) && (wb_dst == ex_rs));
      fwd_b = fwd_pick(mem_valid && mem_reg_wren && (mem_dst != '0) && (mem_dst == ex_rt),
                       wb_reg_wren && (wb_dst != '0) && (wb_dst == ex_rt));
    end
  end

endmodule

// File: tb/tb_ctrl_pipeline.sv
// tb/tb_ctrl_pipeline.sv - directed checks of ctrl_pipeline with and without forwarding
module tb_ctrl_pipeline;

  logic       clk;
  logic       rst_n;
  logic       id_valid, id_reg_wren, id_mem_to_reg, id_mem_wr, id_alu_src, id_dst_reg_sel, id_branch;
  logic [3:0] id_rs, id_rt, id_rd;
  logic       id_rs_used, id_rt_used, ex_br_taken, mem_busy;

  logic       ex_valid, ex_reg_wren, ex_mem_to_reg, ex_mem_wr, ex_alu_src, ex_branch;
  logic [3:0] ex_rs, ex_rt, wb_dst;
  logic       mem_valid, mem_reg_wren, mem_mem_to_reg, mem_mem_wr, wb_reg_wren, wb_mem_to_reg;
  logic [1:0] fwd_a, fwd_b;
  logic       stall_fe, flush_fe;

  logic       n_ex_valid, n_ex_reg_wren, n_ex_mem_to_reg, n_ex_mem_wr, n_ex_alu_src, n_ex_branch;
  logic [3:0] n_ex_rs, n_ex_rt, n_wb_dst;
  logic       n_mem_valid, n_mem_reg_wren, n_mem_mem_to_reg, n_mem_mem_wr, n_wb_reg_wren, n_wb_mem_to_reg;
  logic [1:0] n_fwd_a, n_fwd_b;
  logic       n_stall_fe, n_flush_fe;

  int tests;
  int fails;

  ctrl_pipeline #(.REG_W(4), .FWD_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_reg_wren(id_reg_wren),
    .id_mem_to_reg(id_mem_to_reg), .id_mem_wr(id_mem_wr), .id_alu_src(id_alu_src),
    .id_dst_reg_sel(id_dst_reg_sel), .id_branch(id_branch), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .ex_br_taken(ex_br_taken),
    .mem_busy(mem_busy), .ex_valid(ex_valid), .ex_reg_wren(ex_reg_wren),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_mem_wr(ex_mem_wr), .ex_alu_src(ex_alu_src),
    .ex_branch(ex_branch), .ex_rs(ex_rs), .ex_rt(ex_rt), .mem_valid(mem_valid),
    .mem_reg_wren(mem_reg_wren), .mem_mem_to_reg(mem_mem_to_reg), .mem_mem_wr(mem_mem_wr),
    .wb_reg_wren(wb_reg_wren), .wb_mem_to_reg(wb_mem_to_reg), .wb_dst(wb_dst),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_fe(stall_fe), .flush_fe(flush_fe)
  );

  ctrl_pipeline #(.REG_W(4), .FWD_EN(1'b0)) dut_nofwd (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_reg_wren(id_reg_wren),
    .id_mem_to_reg(id_mem_to_reg), .id_mem_wr(id_mem_wr), .id_alu_src(id_alu_src),
    .id_dst_reg_sel(id_dst_reg_sel), .id_branch(id_branch), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .ex_br_taken(ex_br_taken),
    .mem_busy(mem_busy), .ex_valid(n_ex_valid), .ex_reg_wren(n_ex_reg_wren),
    .ex_mem_to_reg(n_ex_mem_to_reg), .ex_mem_wr(n_ex_mem_wr), .ex_alu_src(n_ex_alu_src),
    .ex_branch(n_ex_branch), .ex_rs(n_ex_rs), .ex_rt(n_ex_rt), .mem_valid(n_mem_valid),
    .mem_reg_wren(n_mem_reg_wren), .mem_mem_to_reg(n_mem_mem_to_reg), .mem_mem_wr(n_mem_mem_wr),
    .wb_reg_wren(n_wb_reg_wren), .wb_mem_to_reg(n_wb_mem_to_reg), .wb_dst(n_wb_dst),
    .fwd_a(n_fwd_a), .fwd_b(n_fwd_b), .stall_fe(n_stall_fe), .flush_fe(n_flush_fe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic wren, input logic m2r, input logic mw,
                        input logic asrc, input logic dsel, input logic br,
                        input logic [3:0] rs, input logic [3:0] rt, input logic [3:0] rd,
                        input logic rsu, input logic rtu);
    id_valid = v; id_reg_wren = wren; id_mem_to_reg = m2r; id_mem_wr = mw;
    id_alu_src = asrc; id_dst_reg_sel = dsel; id_branch = br;
    id_rs = rs; id_rt = rt; id_rd = rd; id_rs_used = rsu; id_rt_used = rtu;
  endtask

  task automatic nop();
    set_id(0, 0, 0, 0, 0, 0, 0, 4'd0, 4'd0, 4'd0, 0, 0);
  endtask
  task automatic alu(input logic [3:0] rd, input logic [3:0] rs, input logic [3:0] rt);
    set_id(1, 1, 0, 0, 0, 1, 0, rs, rt, rd, 1, 1);
  endtask
  task automatic lw(input logic [3:0] rt, input logic [3:0] rs);
    set_id(1, 1, 1, 0, 1, 0, 0, rs, rt, 4'd0, 1, 0);
  endtask
  task automatic sw(input logic [3:0] rt, input logic [3:0] rs);
    set_id(1, 0, 0, 1, 1, 0, 0, rs, rt, 4'd0, 1, 1);
  endtask
  task automatic br(input logic [3:0] rs, input logic [3:0] rt);
    set_id(1, 0, 0, 0, 0, 0, 1, rs, rt, 4'd0, 1, 1);
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b1;
    ex_br_taken = 1'b0;
    mem_busy = 1'b0;
    nop();
    #1 rst_n = 1'b0;
    cyc();
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_wb_reg_wren", wb_reg_wren, 0);
    chk("rst_wb_dst", wb_dst, 0);
    chk("rst_fwd_a", fwd_a, 0);
    chk("rst_stall", stall_fe, 0);
    chk("rst_flush", flush_fe, 0);
    rst_n = 1'b1;
    cyc();

    // LW R1 then ADD R2,R1,R3
    lw(4'd1, 4'd5); #1;
    chk("lw_no_stall", stall_fe, 0);
    cyc();
    alu(4'd2, 4'd1, 4'd3); #1;
    chk("lu_stall", stall_fe, 1);
    chk("lu_ex_is_load", ex_mem_to_reg, 1);
    cyc(); #1;
    chk("lu_bubble", ex_valid, 0);
    chk("lu_load_in_mem", mem_mem_to_reg, 1);
    chk("lu_stall_once", stall_fe, 0);
    cyc(); #1;
    chk("lu_add_in_ex", ex_valid, 1);
    chk("lu_fwd_a_wb", fwd_a, 2'b10);
    chk("lu_fwd_b_reg", fwd_b, 2'b00);
    chk("lu_wb_dst", wb_dst, 1);
    chk("lu_wb_m2r", wb_mem_to_reg, 1);

    // ADD R1 then SUB R4,R1,R1 back-to-back
    alu(4'd1, 4'd5, 4'd6);
    cyc();
    alu(4'd4, 4'd1, 4'd1); #1;
    chk("raw_no_stall", stall_fe, 0);
    cyc(); #1;
    chk("raw_fwd_a_mem", fwd_a, 2'b01);
    chk("raw_fwd_b_mem", fwd_b, 2'b01);
    nop();
    cyc();

    // same pair with one NOP in between
    alu(4'd1, 4'd5, 4'd6);
    cyc();
    nop();
    cyc();
    alu(4'd4, 4'd1, 4'd1); #1;
    chk("gap_no_stall", stall_fe, 0);
    cyc(); #1;
    chk("gap_fwd_a_wb", fwd_a, 2'b10);
    chk("gap_fwd_b_wb", fwd_b, 2'b10);
    nop();
    cyc();

    // writes to R0 never forward or stall
    alu(4'd0, 4'd5, 4'd6);
    cyc();
    alu(4'd2, 4'd0, 4'd0); #1;
    chk("r0_no_stall", stall_fe, 0);
    cyc(); #1;
    chk("r0_fwd_a", fwd_a, 2'b00);
    chk("r0_fwd_b", fwd_b, 2'b00);
    nop();
    cyc();
    cyc();

    // taken branch in EX squashes the wrong-path store
    br(4'd1, 4'd2);
    cyc();
    sw(4'd4, 4'd3);
    ex_br_taken = 1'b1; #1;
    chk("br_flush", flush_fe, 1);
    chk("br_no_stall", stall_fe, 0);
    cyc(); #1;
    chk("br_bubble", ex_valid, 0);
    chk("br_in_mem", mem_valid, 1);
    chk("br_mem_wr0", mem_mem_wr, 0);
    nop();
    ex_br_taken = 1'b0; #1;
    chk("br_flush_once", flush_fe, 0);
    cyc(); #1;
    chk("br_sw_never_mem", mem_mem_wr, 0);

    // memory busy three cycles with a taken branch in EX
    br(4'd1, 4'd2);
    cyc();
    sw(4'd4, 4'd3);
    ex_br_taken = 1'b1;
    mem_busy = 1'b1; #1;
    chk("busy_no_flush", flush_fe, 0);
    chk("busy_stall", stall_fe, 1);
    for (int i = 0; i < 3; i++) begin
      cyc(); #1;
      chk("busy_ex_hold", ex_branch, 1);
      chk("busy_ex_rs_hold", ex_rs, 1);
      chk("busy_flush0", flush_fe, 0);
    end
    mem_busy = 1'b0; #1;
    chk("busy_rel_flush", flush_fe, 1);
    chk("busy_rel_stall", stall_fe, 0);
    cyc(); #1;
    chk("busy_rel_bubble", ex_valid, 0);
    chk("busy_rel_br_mem", mem_valid, 1);
    chk("busy_rel_mem_wr", mem_mem_wr, 0);
    nop();
    ex_br_taken = 1'b0;
    cyc();

    // asynchronous reset mid-stream
    alu(4'd1, 4'd5, 4'd6);
    cyc(); #1;
    chk("pre_rst_ex_valid", ex_valid, 1);
    rst_n = 1'b0; #1;
    chk("arst_ex_valid", ex_valid, 0);
    chk("arst_ex_wren", ex_reg_wren, 0);
    chk("arst_ex_rs", ex_rs, 0);
    chk("arst_wb_reg_wren", wb_reg_wren, 0);
    chk("arst_stall", stall_fe, 0);
    #2 rst_n = 1'b1;
    cyc(); #1;
    chk("post_rst_ex_valid", ex_valid, 1);
    chk("post_rst_ex_wren", ex_reg_wren, 1);
    chk("post_rst_n_ex_valid", n_ex_valid, 1);

    // ADD R1 in EX, SUB R4,R1,R1 in ID: forwarding vs. no forwarding
    alu(4'd4, 4'd1, 4'd1); #1;
    chk("fwd_on_no_stall", stall_fe, 0);
    chk("nofwd_stall_1", n_stall_fe, 1);
    cyc(); #1;
    chk("fwd_on_fwd_a", fwd_a, 2'b01);
    chk("nofwd_bubble", n_ex_valid, 0);
    chk("nofwd_stall_2", n_stall_fe, 1);
    cyc(); #1;
    chk("nofwd_stall_end", n_stall_fe, 0);
    cyc(); #1;
    chk("nofwd_sub_in_ex", n_ex_valid, 1);
    chk("nofwd_ex_rs", n_ex_rs, 1);
    chk("nofwd_fwd_a", n_fwd_a, 2'b00);
    chk("nofwd_fwd_b", n_fwd_b, 2'b00);
    nop();
    cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
